// File: rtl/cromatic_pkg.sv
// Shared encodings and helpers for the chromatic PWM sweep block.
package cromatic_pkg;

  typedef enum logic [1:0] {
    MODE_SWEEP    = 2'd0,
    MODE_MANUAL   = 2'd1,
    MODE_PASSTHRU = 2'd2,
    MODE_OFF      = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    PH_0 = 3'd0,
    PH_1 = 3'd1,
    PH_2 = 3'd2,
    PH_3 = 3'd3,
    PH_4 = 3'd4,
    PH_5 = 3'd5
  } phase_t;

  // Full-scale duty and PWM period length for a given resolution.
  function automatic int unsigned pmax(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/cromatic_pwm_channel.sv
// One colour channel: period-aligned shadow duty, compare against the shared
// counter, per-LED mask, and a 2-flop synchroniser for the external PWM pin.
module cromatic_pwm_channel
  import cromatic_pkg::*;
#(
  parameter int unsigned N_LEDS   = 25,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wrap,
  input  logic [PWM_BITS-1:0] src_duty,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic [1:0]          shadow_mode,
  input  logic                pwm_pin,
  input  logic [N_LEDS-1:0]   led_mask,
  output logic [N_LEDS-1:0]   drive
);

  logic [PWM_BITS-1:0] shadow_duty;
  logic                sync_q1;
  logic                sync_q2;
  logic                on;
  mode_t               smode;

  assign smode = mode_t'(shadow_mode);

  always_comb begin
    on = 1'b0;
    case (smode)
      MODE_SWEEP,
      MODE_MANUAL:   on = (cnt < shadow_duty);
      MODE_PASSTHRU: on = sync_q2;
      default:       on = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_duty <= '0;
      sync_q1     <= 1'b0;
      sync_q2     <= 1'b0;
      drive       <= '0;
    end else begin
      sync_q1 <= pwm_pin;
      sync_q2 <= sync_q1;
      if (wrap) begin
        shadow_duty <= src_duty;
      end
      drive <= led_mask & {N_LEDS{on}};
    end
  end

endmodule

// File: rtl/cromatic_pwm_sweep.sv
// RGB PWM generator for an N-LED matrix: hue-wheel sweep, manual colour or
// legacy pin passthrough, with all changes applied on PWM period boundaries.
module cromatic_pwm_sweep
  import cromatic_pkg::*;
#(
  parameter int unsigned N_LEDS   = 25,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned STEP_DIV = 65536
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic                sweep_en,
  input  logic [PWM_BITS-1:0] duty_r,
  input  logic [PWM_BITS-1:0] duty_g,
  input  logic [PWM_BITS-1:0] duty_b,
  input  logic                R_pwm_input,
  input  logic                G_pwm_input,
  input  logic                B_pwm_input,
  input  logic [N_LEDS-1:0]   led_mask,
  output logic [N_LEDS-1:0]   R,
  output logic [N_LEDS-1:0]   G,
  output logic [N_LEDS-1:0]   B,
  output logic                period_start,
  output logic [2:0]          hue_phase
);

  localparam int unsigned       PMAX     = pmax(PWM_BITS);
  localparam logic [PWM_BITS-1:0] PMAX_V   = PWM_BITS'(PMAX);
  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'(PMAX - 1);
  localparam int unsigned       PS_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(STEP_DIV - 1);

  mode_t               live_mode;
  logic [1:0]          shadow_mode;
  logic [PWM_BITS-1:0] cnt;
  logic                wrap;
  logic [PS_W-1:0]     prescaler;
  logic                sweep_run;
  logic                step;

  phase_t              phase, phase_next;
  logic [PWM_BITS-1:0] work_r, work_g, work_b;
  logic [PWM_BITS-1:0] work_r_next, work_g_next, work_b_next;
  logic [PWM_BITS-1:0] src_r, src_g, src_b;

  assign live_mode = mode_t'(mode);
  assign wrap      = (cnt == CNT_LAST);
  assign sweep_run = (live_mode == MODE_SWEEP) && sweep_en;
  assign step      = sweep_run && (prescaler == PS_LAST);
  assign hue_phase = phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      period_start <= 1'b0;
      prescaler    <= '0;
      shadow_mode  <= MODE_OFF;
    end else begin
      cnt          <= wrap ? '0 : cnt + 1'b1;
      period_start <= wrap;
      if (wrap) begin
        shadow_mode <= mode;
      end
      if (sweep_run) begin
        prescaler <= (prescaler == PS_LAST) ? '0 : prescaler + 1'b1;
      end
    end
  end

  // Ramps saturate at their end value, so a channel already at its limit
  // only advances the phase instead of wrapping the duty.
  always_comb begin
    phase_next  = phase;
    work_r_next = work_r;
    work_g_next = work_g;
    work_b_next = work_b;
    if (step) begin
      case (phase)
        PH_0: begin
          if (work_g >= PMAX_V - 1'b1) begin
            work_g_next = PMAX_V;
            phase_next  = PH_1;
          end else begin
            work_g_next = work_g + 1'b1;
          end
        end
        PH_1: begin
          if (work_r <= 1) begin
            work_r_next = '0;
            phase_next  = PH_2;
          end else begin
            work_r_next = work_r - 1'b1;
          end
        end
        PH_2: begin
          if (work_b >= PMAX_V - 1'b1) begin
            work_b_next = PMAX_V;
            phase_next  = PH_3;
          end else begin
            work_b_next = work_b + 1'b1;
          end
        end
        PH_3: begin
          if (work_g <= 1) begin
            work_g_next = '0;
            phase_next  = PH_4;
          end else begin
            work_g_next = work_g - 1'b1;
          end
        end
        PH_4: begin
          if (work_r >= PMAX_V - 1'b1) begin
            work_r_next = PMAX_V;
            phase_next  = PH_5;
          end else begin
            work_r_next = work_r + 1'b1;
          end
        end
        PH_5: begin
          if (work_b <= 1) begin
            work_b_next = '0;
            phase_next  = PH_0;
          end else begin
            work_b_next = work_b - 1'b1;
          end
        end
        default: phase_next = PH_0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  <= PH_0;
      work_r <= PMAX_V;
      work_g <= '0;
      work_b <= '0;
    end else begin
      phase  <= phase_next;
      work_r <= work_r_next;
      work_g <= work_g_next;
      work_b <= work_b_next;
    end
  end

  always_comb begin
    src_r = '0;
    src_g = '0;
    src_b = '0;
    case (live_mode)
      MODE_SWEEP: begin
        src_r = work_r;
        src_g = work_g;
        src_b = work_b;
      end
      MODE_MANUAL: begin
        src_r = duty_r;
        src_g = duty_g;
        src_b = duty_b;
      end
      default: begin
        src_r = '0;
        src_g = '0;
        src_b = '0;
      end
    endcase
  end

  cromatic_pwm_channel #(.N_LEDS(N_LEDS), .PWM_BITS(PWM_BITS)) u_chan_r (
    .clk(clk), .rst_n(rst_n), .wrap(wrap), .src_duty(src_r), .cnt(cnt),
    .shadow_mode(shadow_mode), .pwm_pin(R_pwm_input), .led_mask(led_mask),
    .drive(R)
  );

  cromatic_pwm_channel #(.N_LEDS(N_LEDS), .PWM_BITS(PWM_BITS)) u_chan_g (
    .clk(clk), .rst_n(rst_n), .wrap(wrap), .src_duty(src_g), .cnt(cnt),
    .shadow_mode(shadow_mode), .pwm_pin(G_pwm_input), .led_mask(led_mask),
    .drive(G)
  );

  cromatic_pwm_channel #(.N_LEDS(N_LEDS), .PWM_BITS(PWM_BITS)) u_chan_b (
    .clk(clk), .rst_n(rst_n), .wrap(wrap), .src_duty(src_b), .cnt(cnt),
    .shadow_mode(shadow_mode), .pwm_pin(B_pwm_input), .led_mask(led_mask),
    .drive(B)
  );

endmodule

// File: tb/tb_cromatic_pwm_sweep.sv
// Directed bench for cromatic_pwm_sweep with PWM_BITS=4 (15-clock period), STEP_DIV=2.
module tb_cromatic_pwm_sweep;

  localparam int N  = 25;
  localparam int PB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    mode = 2'd3;
  logic          sweep_en = 1'b0;
  logic [PB-1:0] duty_r = '0, duty_g = '0, duty_b = '0;
  logic          rp = 1'b0, gp = 1'b0, bp = 1'b0;
  logic [N-1:0]  led_mask = '1;
  logic [N-1:0]  R, G, B;
  logic          period_start;
  logic [2:0]    hue_phase;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cromatic_pwm_sweep #(.N_LEDS(N), .PWM_BITS(PB), .STEP_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sweep_en(sweep_en),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
    .R_pwm_input(rp), .G_pwm_input(gp), .B_pwm_input(bp),
    .led_mask(led_mask), .R(R), .G(G), .B(B),
    .period_start(period_start), .hue_phase(hue_phase)
  );

  typedef struct {
    logic [1:0]   mode;
    logic [PB-1:0] dr, dg, db;
    logic [N-1:0] mask;
    logic [2:0]   pins;
    int           er, eg, eb;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ps(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!period_start && n < 40);
    check({name, "_ps_wait"}, int'(period_start), 1);
  endtask

  // Samples the 15 clocks following a period_start sample.
  task automatic measure(output int rc, output int gc, output int bc,
                         output int patok, output int psok);
    rc = 0; gc = 0; bc = 0; patok = 1; psok = 1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (R == led_mask) rc++; else if (R != '0) patok = 0;
      if (G == led_mask) gc++; else if (G != '0) patok = 0;
      if (B == led_mask) bc++; else if (B != '0) patok = 0;
      if (period_start != (i == 15)) psok = 0;
    end
  endtask

  task automatic do_reset;
    tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  bit gh[1:180];
  bit rh[1:180];
  int ph[1:180];
  int pss[1:180];

  initial begin
    int rc, gc, bc, pok, sok, n, sum;

    vecs[0] = '{2'd1, 4'd5,  4'd0,  4'd15, {N{1'b1}},  3'b000, 5, 0, 15};
    vecs[1] = '{2'd1, 4'd0,  4'd15, 4'd0,  25'h0000001, 3'b000, 0, 15, 0};
    vecs[2] = '{2'd1, 4'd3,  4'd12, 4'd7,  {N{1'b1}},  3'b000, 3, 12, 7};
    vecs[3] = '{2'd3, 4'd9,  4'd9,  4'd9,  {N{1'b1}},  3'b111, 0, 0, 0};
    vecs[4] = '{2'd1, 4'd15, 4'd1,  4'd14, 25'h1555555, 3'b000, 15, 1, 14};
    vecs[5] = '{2'd2, 4'd9,  4'd9,  4'd9,  {N{1'b1}},  3'b101, 15, 0, 15};
    vecs[6] = '{2'd2, 4'd9,  4'd9,  4'd9,  25'h0F0F0F0, 3'b000, 0, 0, 0};

    // Reset state
    repeat (2) tick();
    check("rst_R", int'(R == '0), 1);
    check("rst_G", int'(G == '0), 1);
    check("rst_B", int'(B == '0), 1);
    check("rst_ps", int'(period_start), 0);
    check("rst_phase", int'(hue_phase), 0);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      mode = vecs[v].mode;
      duty_r = vecs[v].dr; duty_g = vecs[v].dg; duty_b = vecs[v].db;
      led_mask = vecs[v].mask;
      {rp, gp, bp} = vecs[v].pins;
      repeat (3) tick();
      wait_ps($sformatf("vec%0d", v));
      measure(rc, gc, bc, pok, sok);
      check($sformatf("vec%0d_r", v), rc, vecs[v].er);
      check($sformatf("vec%0d_g", v), gc, vecs[v].eg);
      check($sformatf("vec%0d_b", v), bc, vecs[v].eb);
      check($sformatf("vec%0d_pattern", v), pok, 1);
      check($sformatf("vec%0d_period", v), sok, 1);
    end

    // Duty change mid-period only affects the next period
    mode = 2'd1; duty_r = 4'd3; duty_g = 4'd0; duty_b = 4'd0; led_mask = '1;
    {rp, gp, bp} = 3'b000;
    repeat (3) tick();
    wait_ps("mid");
    rc = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (R == '1) rc++;
      if (i == 2) duty_r = 4'd12;
    end
    check("mid_cur_r", rc, 3);
    check("mid_cur_ps", int'(period_start), 1);
    measure(rc, gc, bc, pok, sok);
    check("mid_next_r", rc, 12);

    // Passthrough pin-to-output latency
    mode = 2'd2;
    repeat (3) tick();
    wait_ps("pt");
    repeat (2) tick();
    check("pt_idle", int'(R == '0), 1);
    rp = 1'b1;
    tick();
    check("pt_lat1", int'(R == '0), 1);
    tick();
    check("pt_lat2", int'(R == '0), 1);
    tick();
    check("pt_lat3", int'(R == '1), 1);
    rp = 1'b0;

    // Full hue wheel from reset
    mode = 2'd0; sweep_en = 1'b1;
    do_reset();
    for (int k = 1; k <= 180; k++) begin
      tick();
      gh[k] = (G == '1);
      rh[k] = (R == '1);
      ph[k] = int'(hue_phase);
      pss[k] = int'(period_start);
    end
    for (int p = 1; p <= 6; p++) begin
      check($sformatf("wheel_pre%0d", p), ph[30*p-1], p - 1);
      check($sformatf("wheel_at%0d", p), ph[30*p], p % 6);
    end
    sum = 0;
    for (int k = 1; k <= 180; k++) sum += pss[k];
    check("wheel_periods", sum, 12);
    check("wheel_first_ps", pss[15], 1);
    sum = 0; for (int k = 16; k <= 30; k++) sum += int'(gh[k]);
    check("wheel_g_p1", sum, 7);
    sum = 0; for (int k = 31; k <= 45; k++) sum += int'(gh[k]);
    check("wheel_g_p2_prestep", sum, 14);
    sum = 0; for (int k = 46; k <= 60; k++) sum += int'(rh[k]);
    check("wheel_r_p3", sum, 8);
    sum = 0; for (int k = 46; k <= 60; k++) sum += int'(gh[k]);
    check("wheel_g_p3", sum, 15);

    // Freeze at phase 2, B=7, then resume
    do_reset();
    repeat (74) tick();
    check("frz_phase_pre", int'(hue_phase), 2);
    sweep_en = 1'b0;
    wait_ps("frz");
    measure(rc, gc, bc, pok, sok);
    check("frz_b", bc, 7);
    check("frz_r", rc, 0);
    check("frz_g", gc, 15);
    repeat (10) tick();
    check("frz_phase_hold", int'(hue_phase), 2);
    sweep_en = 1'b1;
    n = 0;
    while (hue_phase != 3'd3 && n < 100) begin
      tick();
      n++;
    end
    check("resume_clks", n, 16);

    // Asynchronous reset mid-period
    repeat (5) tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_R", int'(R == '0), 1);
    check("arst_G", int'(G == '0), 1);
    check("arst_B", int'(B == '0), 1);
    check("arst_phase", int'(hue_phase), 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("arst_phase_after", int'(hue_phase), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cromatic_pwm_sweep.md
Name: cromatic_pwm_sweep

Overview:
- Parametrised successor to the fixed 25-LED chromatic fan-out block.
- Generates RGB PWM internally, driving every LED of an N-LED matrix.
- Three modes:
  - autonomous hue-wheel sweep through the full chromatic palette;
  - manual static colour from duty inputs;
  - legacy passthrough of external PWM pins.
- Sits between board pins/config and the LED matrix column drivers.

Parameters:
- N_LEDS, 25, LEDs per colour bus (width of R/G/B).
- PWM_BITS, 8, duty resolution; PMAX = 2^PWM_BITS-1 is both PWM period in clocks and full-scale duty.
- STEP_DIV, 65536, clocks per sweep step (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  0=SWEEP, 1=MANUAL, 2=PASSTHRU, 3=OFF
- sweep_en  in  1  1=advance sweep; 0=freeze colour
- duty_r / duty_g / duty_b  in  PWM_BITS each  MANUAL duties, 0..PMAX
- R_pwm_input / G_pwm_input / B_pwm_input  in  1 each  asynchronous external PWM, PASSTHRU only
- led_mask  in  N_LEDS  per-LED enable, 1=on
- R / G / B  out  N_LEDS each  registered LED drive
- period_start  out  1  one-cycle pulse on the first cycle of each PWM period
- hue_phase  out  3  current sweep phase 0..5

Behaviour:
- Reset (async assert, sync release): cnt=0; prescaler=0; phase=0; work duties R=PMAX, G=0, B=0; shadow duties=0; shadow mode=OFF; sync flops=0; R/G/B=0; period_start=0; hue_phase=0.
- PWM counter cnt:
  - counts 0..PMAX-1, then wraps to 0;
  - wrap event = clock where cnt==PMAX-1;
  - period_start registered, high the cycle cnt==0.
- Shadowing: on wrap only, latch mode into shadow mode and source duties into shadow duties. Source = work duties (SWEEP), duty_* (MANUAL), or 0 (OFF/PASSTHRU). No mid-period glitches; mode/duty changes take effect at the next period.
- Output, per colour c, LED i, registered: c[i] <= led_mask[i] & (cnt < shadow_c). Latency 1 clock.
  - Duty 0 => constant 0.
  - Duty PMAX => constant 1.
- PASSTHRU (shadow mode 2): external pins pass through 2-flop synchronisers, then c[i] <= led_mask[i] & sync_c. Pin-to-output latency 3 clocks. Synchronisers run in all modes.
- OFF (mode 3) and illegal states: outputs 0.
- Sweep engine runs only when live mode==SWEEP and sweep_en==1; otherwise prescaler and work duties hold.
  - Prescaler counts 0..STEP_DIV-1; at terminal count, the phase's ramping channel moves ±1.
  - Phases (ramp, end condition):
    - 0 G up to PMAX;
    - 1 R down to 0;
    - 2 B up to PMAX;
    - 3 G down to 0;
    - 4 R up to PMAX;
    - 5 B down to 0.
  - When the ramping channel reaches its end value on a step, phase advances (5 wraps to 0) on that same clock; the next step ramps the new channel.
  - Full cycle = 6*PMAX steps.
  - Work duties never leave 0..PMAX (no overflow/underflow).
- Simultaneous step and wrap: the shadow latches pre-step work duties; the new step value appears next period.
- Re-entering SWEEP resumes from frozen work state; no reset of phase.
- Mid-operation rst_n low: all state cleared immediately, outputs 0 within the asynchronous reset path.

Decomposition:
- Package cromatic_pkg: mode encodings (MODE_SWEEP/MANUAL/PASSTHRU/OFF), phase encodings PH_0..PH_5, function pmax(PWM_BITS).
- One sub-module: cromatic_pwm_channel (shadow duty register, compare, mask, passthrough sync), instantiated three times.
- Sweep FSM and counters stay in the top.

Test Plan (PWM_BITS=4 so PMAX=15, STEP_DIV=2, N_LEDS=25):
- Reset, then MANUAL, duty_r=5, duty_g=0, duty_b=15, mask all 1s:
  - after first wrap, each 15-clk period has R=all-1s for exactly 5 clks;
  - G always 0; B always all-1s;
  - period_start every 15 clks.
- MANUAL with mask=25'h0000001, duty_g=15 -> only G[0]=1; all other bits 0.
- SWEEP, sweep_en=1 from reset:
  - G increments every 2 clks; phase 0->1 at G=15 (30 clks);
  - hue_phase sequence 0..5,0;
  - full wheel = 180 clks;
  - observed duty matches work duty one period late.
- Change duty_r 3->12 mid-period -> current period still 3 high clks; next period 12.
- PASSTHRU: toggle R_pwm_input -> R==all-1s 3 clks later (after mode takes effect at wrap).
- SWEEP with sweep_en dropped at phase 2, B=7 -> duties frozen; resume continues from B=7; rst_n pulse mid-period -> all outputs 0 immediately, state back to phase 0.
